led_pwm: RTL

Wishbone-writable LED driver: the output-side counterpart to the button input peripheral on the same CPU bus. The CPU writes per-LED 8-bit brightness and an optional blink pattern; the block generates glitch-free PWM on the LED pins, with duty updates applied only at frame boundaries. It also supports readback of all registers and the current blink phase.

---
 rtl/led_pwm.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/led_pwm.sv
// Wishbone-writable LED PWM driver: per-LED 8-bit duty with frame-aligned shadow copy,
// optional blink masking, and readback of all registers plus live PWM/blink status.
module led_pwm #(
    parameter int NUM_LEDS     = 2,
    parameter int PRESCALE_DIV = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wb_cyc,
    input  logic                wb_we,
    input  logic [3:0]          wb_addr,
    input  logic [31:0]         wb_wdata,
    output logic [31:0]         wb_rdata,
    output logic                wb_ack,
    output logic [NUM_LEDS-1:0] led
);

    localparam int              PS_W        = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST     = PS_W'(PRESCALE_DIV - 1);
    localparam logic [3:0]      ADDR_MASK   = 4'd8;
    localparam logic [3:0]      ADDR_PERIOD = 4'd9;
    localparam logic [3:0]      ADDR_STATUS = 4'd10;

    logic [PS_W-1:0]     presc_q, presc_d;
    logic [7:0]          pwm_cnt_q, pwm_cnt_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [7:0]          duty_q [NUM_LEDS];
    logic [7:0]          duty_d [NUM_LEDS];
    logic [7:0]          active_duty_q [NUM_LEDS];
    logic [7:0]          active_duty_d [NUM_LEDS];
    logic [NUM_LEDS-1:0] blink_mask_q, blink_mask_d;
    logic [15:0]         blink_period_q, blink_period_d;
    logic                ack_q, ack_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [NUM_LEDS-1:0] led_q, led_d;

    logic tick;
    logic frame_end;
    logic access;
    logic wr_en;
    logic rd_en;
    logic period_wr;
    logic unused_wdata;

    assign tick      = (presc_q == PS_LAST);
    assign frame_end = tick && (pwm_cnt_q == 8'hFF);

    // Each ack is exactly one access; a held cyc re-arms on the cycle after ack.
    assign access    = wb_cyc && !ack_q;
    assign wr_en     = access && wb_we;
    assign rd_en     = access && !wb_we;
    assign period_wr = wr_en && (wb_addr == ADDR_PERIOD);

    assign unused_wdata = &{1'b0, wb_wdata[31:16]};

    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        presc_d   = tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        ack_d     = access;
    end

    always_comb begin
        duty_d         = duty_q;
        active_duty_d  = active_duty_q;
        blink_mask_d   = blink_mask_q;
        blink_period_d = blink_period_q;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (wr_en && (wb_addr == 4'(i))) begin
                duty_d[i] = wb_wdata[7:0];
            end
            // Shadow copy samples the pre-write register, so a write landing on
            // the boundary edge waits for the following frame.
            if (frame_end) begin
                active_duty_d[i] = duty_q[i];
            end
        end
        if (wr_en && (wb_addr == ADDR_MASK)) begin
            blink_mask_d = wb_wdata[NUM_LEDS-1:0];
        end
        if (period_wr) begin
            blink_period_d = wb_wdata[15:0];
        end
    end

    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (period_wr) begin
            frame_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (frame_end) begin
            if (blink_period_q == 16'd0) begin
                frame_cnt_d   = '0;
                blink_phase_d = 1'b0;
            end else if (frame_cnt_q == blink_period_q - 16'd1) begin
                frame_cnt_d   = '0;
                blink_phase_d = !blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        if (rd_en) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (wb_addr == 4'(i)) begin
                    rdata_d = {24'b0, duty_q[i]};
                end
            end
            if (wb_addr == ADDR_MASK) begin
                rdata_d = 32'(blink_mask_q);
            end else if (wb_addr == ADDR_PERIOD) begin
                rdata_d = {16'b0, blink_period_q};
            end else if (wb_addr == ADDR_STATUS) begin
                rdata_d = {16'b0, pwm_cnt_q, 7'b0, blink_phase_q};
            end
        end
    end

    always_comb begin
        led_d = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            led_d[i] = (pwm_cnt_q < active_duty_q[i]) && !(blink_mask_q[i] && blink_phase_q);
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q        <= '0;
            pwm_cnt_q      <= '0;
            frame_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            // NOTE: the duty arrays are a few flops, not a RAM, and software relies
            // on them reading 0 after reset, so they are reset like any other state.
            duty_q         <= '{default: '0};
            active_duty_q  <= '{default: '0};
            blink_mask_q   <= '0;
            blink_period_q <= '0;
            ack_q          <= 1'b0;
            rdata_q        <= '0;
            led_q          <= '0;
        end else begin
            presc_q        <= presc_d;
            pwm_cnt_q      <= pwm_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
            blink_phase_q  <= blink_phase_d;
            duty_q         <= duty_d;
            active_duty_q  <= active_duty_d;
            blink_mask_q   <= blink_mask_d;
            blink_period_q <= blink_period_d;
            ack_q          <= ack_d;
            rdata_q        <= rdata_d;
            led_q          <= led_d;
        end
    end

    assign wb_ack   = ack_q;
    assign wb_rdata = rdata_q;
    assign led      = led_q;

endmodule
